mmio_memory_ctrl: RTL
=====================

// Module: mmio_memory_ctrl
// PURPOSE
//  Memory + memory-mapped I/O subsystem for the MIPS datapath: word RAM plus NUM_IN input ports, NUM_OUT output ports and a sticky status register.
//  Adds explicit read/write strobes, byte enables, a 1-cycle read handshake (rd_valid) and per-outport write strobes.
//  Sits between the datapath memory-address/write-data registers and the memory-data register.
// PARAMETERS
//  WIDTH          32            data width; multiple of 8
//  ADDR_WIDTH     32            address bus width
//  NUM_IN         2             input ports, 1..16
//  NUM_OUT        1             output ports, 1..16
//  RAM_ADDR_BITS  8             RAM depth = 2**RAM_ADDR_BITS words
//  IO_BASE        32'h0000FF00  base of 256-byte I/O window; 256-byte aligned
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous, active-high reset
//  address      in   ADDR_WIDTH        byte address; bits [1:0] ignored
//  wr_data      in   WIDTH             write data
//  wr_be        in   WIDTH/8           byte enables for the write
//  mem_write    in   1                 write strobe, one access per cycle
//  mem_read     in   1                 read strobe
//  in_data      in   WIDTH             shared input-port data bus
//  inport_en    in   NUM_IN            bit i loads in_data into inport i
//  rd_data      out  WIDTH             read data, valid when rd_valid=1
//  rd_valid     out  1                 one-cycle pulse, cycle after mem_read
//  outport      out  NUM_OUT*WIDTH     output ports; port j in [j*WIDTH +: WIDTH]
//  out_strobe   out  NUM_OUT           pulse: outport j updated this cycle
// BEHAVIOUR
//  Address decode, combinational on address:
//   - address <  IO_BASE: RAM, word index address[RAM_ADDR_BITS+1:2]; higher bits alias.
//   - IO_BASE+4*i, i<NUM_IN: inport i (read-only).
//   - IO_BASE+0x80+4*j, j<NUM_OUT: outport j (read/write).
//   - IO_BASE+0xFC: STATUS (read-only).
//   - Other I/O offsets: read 0; writes ignored.
//   - address >= IO_BASE+0x100: RAM, aliased.
//  RAM
//   - Synchronous, inferred, not cleared by reset.
//   - Write when mem_write && RAM hit; only bytes with wr_be[k]=1 are written.
//  Inports
//   - Register i loads in_data on the clk edge when inport_en[i]=1.
//   - Never reset; contents are preserved across rst.
//  Outports
//   - mem_write to outport j: merge wr_data by byte enable into outport j at the clk edge.
//   - out_strobe[j]=1 for the same cycle in which the new value first appears.
//   - A write with wr_be=0 still pulses out_strobe[j]; the value is unchanged.
//  STATUS
//   - Bit i (i<NUM_IN) is sticky; set on any cycle with inport_en[i]=1.
//   - Upper bits read 0.
//   - A mem_read of STATUS returns the current flags and clears them at that edge.
//   - If inport_en[i] is high in that same cycle, set wins: bit i stays 1.
//  Read handshake, latency 1
//   - mem_read high in cycle N: rd_data is registered at edge N+1 with rd_valid=1 for exactly cycle N+1.
//   - Back-to-back reads each produce one rd_valid pulse.
//   - rd_data holds its last value while rd_valid=0.
//   - Inport, outport and STATUS values are sampled at edge N+1, with the same latency as RAM.
//  Read and write in the same cycle, same address
//   - The write is performed.
//   - rd_data returns the pre-write value (RAM read-before-write; I/O registers sampled before update).
//  Reset values
//   - rd_data=0, rd_valid=0, outport=0, out_strobe=0, STATUS=0.
//   - RAM and inports are untouched.
//   - rst asserted mid-read: the pending rd_valid is cancelled and is not issued after release.
// TESTING
//  T1: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rd_valid one cycle later, rd_data=0xDEADBEEF.
//  T2: write 0x11223344 be=4'b0101 over 0xDEADBEEF at 0x10, then read -> 0xDE22BE44.
//  T3: in_data=0x55 with inport_en=2'b10, then read IO_BASE+4 -> 0x55; then read STATUS -> 0x2; second STATUS read -> 0x0.
//  T4: write 0xA5 to IO_BASE+0x80 -> outport[31:0]=0xA5 and out_strobe[0]=1 for one cycle; write to IO_BASE+0x40 -> no change, no strobe.
//  T5: inport_en[0] in the same cycle as a STATUS read -> read returns bit0 per prior state, and bit0=1 afterwards.
//  T6: mem_read, then rst in the next cycle -> no rd_valid; outport=0 and inport contents retained after reset.

Source files
------------

// File: rtl/mmio_memory_ctrl.sv
// Word RAM plus memory-mapped inports, outports and a sticky STATUS register.
// Reads have one cycle of latency. A read and a write in the same cycle return the value from before the write.
module mmio_memory_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned NUM_IN        = 2,
  parameter int unsigned NUM_OUT       = 1,
  parameter int unsigned RAM_ADDR_BITS = 8,
  parameter logic [31:0] IO_BASE       = 32'h0000FF00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH/8-1:0]         wr_be,
  input  logic                       mem_write,
  input  logic                       mem_read,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [NUM_IN-1:0]          inport_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [NUM_OUT*WIDTH-1:0]   outport,
  output logic [NUM_OUT-1:0]         out_strobe
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** RAM_ADDR_BITS;
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [WIDTH-1:0]         inport [NUM_IN];
  logic [NUM_IN-1:0]        status;

  logic                     io_hit;
  logic                     ram_hit;
  logic                     in_hit;
  logic                     out_hit;
  logic                     status_hit;
  logic [5:0]               io_word;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic [NUM_OUT-1:0]       out_wr;
  logic [WIDTH-1:0]         rd_next;
  logic                     unused_addr;

  // The I/O window is 256-byte aligned, so decoding it is a compare of the upper address bits.
  assign io_hit      = (address[ADDR_WIDTH-1:8] == IO_BASE_A[ADDR_WIDTH-1:8]);
  assign ram_hit     = !io_hit;
  assign io_word     = address[7:2];
  assign ram_idx     = address[RAM_ADDR_BITS+1:2];
  assign in_hit      = io_hit && (io_word[5:4] == 2'b00);
  assign out_hit     = io_hit && (io_word[5:4] == 2'b10);
  assign status_hit  = io_hit && (io_word == 6'h3F);
  assign unused_addr = ^address;

  always_comb begin
    out_wr = '0;
    for (int j = 0; j < NUM_OUT; j++)
      out_wr[j] = mem_write && out_hit && (io_word[3:0] == 4'(j));
  end

  // Read mux samples current state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_next = '0;
    if (ram_hit) rd_next = mem[ram_idx];
    for (int i = 0; i < NUM_IN; i++)
      if (in_hit && (io_word[3:0] == 4'(i))) rd_next = inport[i];
    for (int j = 0; j < NUM_OUT; j++)
      if (out_hit && (io_word[3:0] == 4'(j))) rd_next = outport[j*WIDTH +: WIDTH];
    if (status_hit) rd_next = WIDTH'(status);
  end

  // RAM with byte-enabled writes and no reset.
  always_ff @(posedge clk) begin
    if (mem_write && ram_hit)
      for (int k = 0; k < BYTES; k++)
        if (wr_be[k]) mem[ram_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
  end

  // Inports keep their contents through reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++)
      if (inport_en[i]) inport[i] <= in_data;
  end

  // A STATUS read clears the flags, but a load in the same cycle still sets its bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= '0;
    else if (mem_read && status_hit) status <= inport_en;
    else status <= status | inport_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outport    <= '0;
      out_strobe <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        out_strobe[j] <= out_wr[j];
        if (out_wr[j])
          for (int k = 0; k < BYTES; k++)
            if (wr_be[k]) outport[j*WIDTH + k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= mem_read;
      if (mem_read) rd_data <= rd_next;
    end
  end

endmodule
